// File: rtl/lvt_word_mux_pipe.sv
// LVT word resolver: selects the last writer's bank word and registers it behind a 2-entry skid buffer.
// Optional sticky out-of-range selector flag enabled by macro LVT_MUX_SELCHK_EN.
module lvt_word_mux_pipe #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned NUM_BANKS = 3,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned SEL_W     = 2
) (
  input  logic                        csi_clockreset_clk,
  input  logic                        csi_clockreset_reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_W-1:0]            selector,
  input  logic [NUM_BANKS*WORD_W-1:0] bank_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        err_sel
);

  if (NUM_BANKS != NUM_PORTS - 1) begin : g_bad_banks
    $error("NUM_BANKS must equal NUM_PORTS-1");
  end
  if ((1 << SEL_W) < NUM_PORTS) begin : g_bad_sel_w
    $error("SEL_W too narrow for NUM_PORTS");
  end

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q;
  logic [WORD_W-1:0] out_q;
  logic [WORD_W-1:0] skid_q;
  logic              rdy_q;
  logic [WORD_W-1:0] word;
  logic [31:0]       sel_ext;
  logic              sel_bad;
  logic              accept;
  logic              drain;

  // Writers 0 and 1 share bank 0; writer s >= 2 lives in bank s-1.
  always_comb begin
    sel_ext = 32'(selector);
    sel_bad = (sel_ext >= NUM_PORTS);
    word    = '0;
    if (!sel_bad) begin
      if (sel_ext < 32'd2) begin
        word = bank_data[0 +: WORD_W];
      end else begin
        for (int unsigned k = 1; k < NUM_BANKS; k++) begin
          if (sel_ext == k + 1) word = bank_data[k*WORD_W +: WORD_W];
        end
      end
    end
  end

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = rdy_q && (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = out_q;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
    if (!csi_clockreset_reset_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        StEmpty: begin
          if (accept) begin
            out_q   <= word;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && drain) begin
            out_q <= word;
          end else if (accept) begin
            skid_q  <= word;
            state_q <= StFull;
          end else if (drain) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (drain) begin
            out_q   <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

`ifdef LVT_MUX_SELCHK_EN
  logic err_q;

  always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
    if (!csi_clockreset_reset_n) begin
      err_q <= 1'b0;
    end else if (accept && sel_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err_sel = err_q;
`else
  assign err_sel = 1'b0;
`endif

endmodule

// File: tb/tb_lvt_word_mux_pipe.sv
// Self-checking bench for lvt_word_mux_pipe: queue-based reference model plus directed cases
// on the default, 3-port and 8-port/64-bit configurations.
module tb_lvt_word_mux_pipe;

`ifdef LVT_MUX_SELCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default configuration
  logic        in_valid, in_ready, out_valid, out_ready, err_sel;
  logic [1:0]  selector;
  logic [95:0] bank_data;
  logic [31:0] out_data;

  lvt_word_mux_pipe dut (
    .csi_clockreset_clk    (clk),
    .csi_clockreset_reset_n(rst_n),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .selector              (selector),
    .bank_data             (bank_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .err_sel               (err_sel)
  );

  // Three-writer configuration: selector 3 is out of range
  logic        d3_valid, d3_ready, d3_ovalid, d3_err;
  logic [1:0]  d3_sel;
  logic [63:0] d3_banks;
  logic [31:0] d3_data;

  lvt_word_mux_pipe #(.NUM_PORTS(3), .NUM_BANKS(2), .WORD_W(32), .SEL_W(2)) dut3 (
    .csi_clockreset_clk    (clk),
    .csi_clockreset_reset_n(rst_n),
    .in_valid              (d3_valid),
    .in_ready              (d3_ready),
    .selector              (d3_sel),
    .bank_data             (d3_banks),
    .out_valid             (d3_ovalid),
    .out_ready             (1'b1),
    .out_data              (d3_data),
    .err_sel               (d3_err)
  );

  // Wide configuration
  logic         d8_valid, d8_ready, d8_ovalid, d8_err;
  logic [2:0]   d8_sel;
  logic [447:0] d8_banks;
  logic [63:0]  d8_data;

  lvt_word_mux_pipe #(.NUM_PORTS(8), .NUM_BANKS(7), .WORD_W(64), .SEL_W(3)) dut8 (
    .csi_clockreset_clk    (clk),
    .csi_clockreset_reset_n(rst_n),
    .in_valid              (d8_valid),
    .in_ready              (d8_ready),
    .selector              (d8_sel),
    .bank_data             (d8_banks),
    .out_valid             (d8_ovalid),
    .out_ready             (1'b1),
    .out_data              (d8_data),
    .err_sel               (d8_err)
  );

  // Words accepted but not yet drained, oldest first
  logic [63:0] q[$];

  function automatic logic [63:0] ref_word(input int np, input int sel, input logic [511:0] banks,
                                           input int ww);
    int idx;
    logic [511:0] sh;
    if (sel >= np) return 64'd0;
    idx = (sel < 2) ? 0 : sel - 1;
    sh  = banks >> (idx * ww);
    if (ww >= 64) return sh[63:0];
    return sh[63:0] & ((64'd1 << ww) - 64'd1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, drive one cycle of stimulus, advance to the next negedge.
  task automatic cycle(input logic v, input int sel, input logic [95:0] banks, input logic ordy);
    logic acc, drn;
    check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) check("out_data", {32'd0, out_data}, q[0]);
    in_valid  = v;
    selector  = sel[1:0];
    bank_data = banks;
    out_ready = ordy;
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(ref_word(4, sel, {416'd0, banks}, 32));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [95:0]  b;
    logic [31:0]  exp_map[4];
    rst_n = 1'b0;
    in_valid = 1'b0; selector = '0; bank_data = '0; out_ready = 1'b0;
    d3_valid = 1'b0; d3_sel = '0; d3_banks = '0;
    d8_valid = 1'b0; d8_sel = '0; d8_banks = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_err_sel", {63'd0, err_sel}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mapping with continuous drain
    b = {32'hC, 32'hB, 32'hA};
    exp_map = '{32'hA, 32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, i, b, 1'b1);
      check("map_word", {32'd0, out_data}, {32'd0, exp_map[i]});
    end
    cycle(1'b0, 0, '0, 1'b1);
    cycle(1'b0, 0, '0, 1'b1);

    // Backpressure into FULL, hold, then drain in order
    cycle(1'b1, 0, {64'd0, 32'h11}, 1'b0);
    cycle(1'b1, 0, {64'd0, 32'h22}, 1'b0);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_hold", {32'd0, out_data}, 64'h11);
    cycle(1'b1, 1, {64'd0, 32'h33}, 1'b0);
    check("bp_hold2", {32'd0, out_data}, 64'h11);
    cycle(1'b0, 0, '0, 1'b1);
    check("bp_second", {32'd0, out_data}, 64'h22);
    cycle(1'b0, 0, '0, 1'b1);
    check("bp_empty", {63'd0, out_valid}, 64'd0);

    // Streaming: accept and drain together for 8 words
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, int'($urandom_range(0, 3)), {$urandom, $urandom, $urandom}, 1'b1);
    end
    cycle(1'b0, 0, '0, 1'b1);
    cycle(1'b0, 0, '0, 1'b1);

    // Reset while FULL
    cycle(1'b1, 2, {32'd0, 32'h44, 32'd0}, 1'b0);
    cycle(1'b1, 3, {32'h55, 64'd0}, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_data", {32'd0, out_data}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, '0, 1'b1);

    // Random traffic against the queue model
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
            {$urandom, $urandom, $urandom}, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, '0, 1'b1);

    // Out-of-range selector on the three-writer instance
    d3_sel = 2'd3; d3_valid = 1'b0; d3_banks = {32'h7777, 32'h5555};
    @(negedge clk);
    check("d3_err_idle", {63'd0, d3_err}, 64'd0);
    d3_valid = 1'b1; d3_sel = 2'd2;
    @(negedge clk);
    check("d3_sel2", {32'd0, d3_data}, ref_word(3, 2, {448'd0, d3_banks}, 32));
    check("d3_err_valid", {63'd0, d3_err}, 64'd0);
    d3_sel = 2'd3;
    @(negedge clk);
    d3_valid = 1'b0;
    check("d3_bad_data", {32'd0, d3_data}, 64'd0);
    check("d3_bad_valid", {63'd0, d3_ovalid}, 64'd1);
    check("d3_err_set", {63'd0, d3_err}, {63'd0, ERR_EXP});
    repeat (3) @(negedge clk);
    check("d3_err_sticky", {63'd0, d3_err}, {63'd0, ERR_EXP});

    // Wide instance: selector 7 returns bank 6, selector 1 returns bank 0
    for (int i = 0; i < 14; i++) d8_banks[i*32 +: 32] = $urandom;
    check("d8_ready", {63'd0, d8_ready}, 64'd1);
    d8_valid = 1'b1; d8_sel = 3'd7;
    @(negedge clk);
    check("d8_sel7", d8_data, ref_word(8, 7, {64'd0, d8_banks}, 64));
    d8_sel = 3'd1;
    @(negedge clk);
    d8_valid = 1'b0;
    check("d8_sel1", d8_data, ref_word(8, 1, {64'd0, d8_banks}, 64));
    check("d8_err", {63'd0, d8_err}, 64'd0);
    @(negedge clk);
    check("d8_drained", {63'd0, d8_ovalid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
